// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a word-addressed data memory.
// Loads always read whole words; misaligned stores become ascending byte writes.
module load_store_unit #(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_FUNC3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_DATA,
  output logic              RSP_ERR,
  output logic              M_RD,
  output logic              M_WRT,
  output logic [2:0]        M_FUNC3,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  input  logic [31:0]       M_RDATA,
  output logic [2:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where REQ_VALID && REQ_READY;
  // REQ_READY is high only in IDLE. RSP_VALID is a single-cycle pulse, no back-pressure.
  typedef enum logic [2:0] {S_IDLE, S_LD0, S_LD1, S_ST, S_RESP} state_t;

  state_t             state;
  logic [2:0]         f3;
  logic [1:0]         off;
  logic [1:0]         cnt;
  logic [1:0]         last;
  logic [31:0]        wdata;
  logic [31:0]        lo;
  logic               req_illegal;
  logic               req_misal;
  logic               req_err;
  logic               req_sw_aligned;
  logic [1:0]         req_last;
  logic [1:0]         next_k;
  logic [ADDR_W-1:0]  req_base;

  assign REQ_READY = (state == S_IDLE);
  assign dbg_state = state;

  function automatic logic [31:0] load_result(input logic [63:0] dw, input logic [1:0] sh_off,
                                              input logic [2:0] fn);
    logic [31:0] sh;
    sh = 32'(dw >> {sh_off, 3'b000});
    case (fn)
      3'b000:  load_result = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_result = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_result = {24'd0, sh[7:0]};
      3'b101:  load_result = {16'd0, sh[15:0]};
      default: load_result = sh;
    endcase
  endfunction

  always_comb begin
    req_illegal = REQ_WE ? !(REQ_FUNC3 == 3'b000 || REQ_FUNC3 == 3'b001 || REQ_FUNC3 == 3'b010)
                         : (REQ_FUNC3 == 3'b011 || REQ_FUNC3[2:1] == 2'b11);
    req_misal = (REQ_FUNC3[1:0] == 2'b01 && REQ_ADDR[0]) ||
                (REQ_FUNC3[1:0] == 2'b10 && REQ_ADDR[1:0] != 2'b00);
    req_err        = req_illegal || (req_misal && !ALLOW_MISALIGNED);
    req_sw_aligned = (REQ_FUNC3 == 3'b010) && (REQ_ADDR[1:0] == 2'b00);
    req_base       = {REQ_ADDR[ADDR_W-1:2], 2'b00};
    next_k         = cnt + 2'd1;
    case (REQ_FUNC3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      f3        <= 3'd0;
      off       <= 2'd0;
      cnt       <= 2'd0;
      last      <= 2'd0;
      wdata     <= 32'd0;
      lo        <= 32'd0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 32'd0;
      RSP_ERR   <= 1'b0;
      M_RD      <= 1'b0;
      M_WRT     <= 1'b0;
      M_FUNC3   <= 3'd0;
      M_ADDR    <= '0;
      M_WDATA   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            f3    <= REQ_FUNC3;
            off   <= REQ_ADDR[1:0];
            wdata <= REQ_WDATA;
            last  <= req_last;
            cnt   <= 2'd0;
            if (req_err) begin
              state     <= S_RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_DATA  <= 32'd0;
            end else if (!REQ_WE) begin
              state   <= S_LD0;
              M_RD    <= 1'b1;
              M_FUNC3 <= 3'b010;
              M_ADDR  <= req_base;
            end else if (req_sw_aligned) begin
              state   <= S_ST;
              M_WRT   <= 1'b1;
              M_FUNC3 <= 3'b010;
              M_ADDR  <= req_base;
              M_WDATA <= REQ_WDATA;
              last    <= 2'd0;
            end else begin
              state   <= S_ST;
              M_WRT   <= 1'b1;
              M_FUNC3 <= 3'b000;
              M_ADDR  <= REQ_ADDR;
              M_WDATA <= {24'd0, REQ_WDATA[7:0]};
            end
          end
        end
        S_LD0: begin
          lo <= M_RDATA;
          // The access spills into the next word when offset + size exceeds 4 bytes.
          if ({1'b0, off} + {1'b0, last} > 3'd3) begin
            state  <= S_LD1;
            M_ADDR <= M_ADDR + ADDR_W'(4);
          end else begin
            state     <= S_RESP;
            M_RD      <= 1'b0;
            M_FUNC3   <= 3'd0;
            M_ADDR    <= '0;
            RSP_VALID <= 1'b1;
            RSP_DATA  <= load_result({32'd0, M_RDATA}, off, f3);
          end
        end
        S_LD1: begin
          state     <= S_RESP;
          M_RD      <= 1'b0;
          M_FUNC3   <= 3'd0;
          M_ADDR    <= '0;
          RSP_VALID <= 1'b1;
          RSP_DATA  <= load_result({M_RDATA, lo}, off, f3);
        end
        S_ST: begin
          if (cnt == last) begin
            state     <= S_RESP;
            M_WRT     <= 1'b0;
            M_FUNC3   <= 3'd0;
            M_ADDR    <= '0;
            M_WDATA   <= 32'd0;
            RSP_VALID <= 1'b1;
            RSP_DATA  <= 32'd0;
          end else begin
            cnt     <= next_k;
            M_ADDR  <= M_ADDR + ADDR_W'(1);
            M_WDATA <= {24'd0, wdata[{next_k, 3'b000} +: 8]};
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          RSP_VALID <= 1'b0;
          RSP_ERR   <= 1'b0;
          RSP_DATA  <= 32'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-array memory model, response and
// memory-operation scoreboards, plus a second instance with misalignment disallowed.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid, req_we, req_ready, rsp_valid, rsp_err, m_rd, m_wrt;
  logic [2:0]  req_func3, m_func3, dbg_state;
  logic [31:0] req_addr, req_wdata, rsp_data, m_addr, m_wdata, m_rdata;

  logic        req_valid_b, req_we_b, req_ready_b, rsp_valid_b, rsp_err_b, m_rd_b, m_wrt_b;
  logic [2:0]  req_func3_b, m_func3_b, dbg_state_b;
  logic [31:0] req_addr_b, req_wdata_b, rsp_data_b, m_addr_b, m_wdata_b, m_rdata_b;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [48:0] exp_q[$];
  logic [68:0] exp_m_q[$];
  logic [48:0] rsp_e;
  logic [68:0] mop_e;

  load_store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_FUNC3(req_func3), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .M_RD(m_rd), .M_WRT(m_wrt), .M_FUNC3(m_func3), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_RDATA(m_rdata), .dbg_state(dbg_state)
  );

  load_store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid_b), .REQ_READY(req_ready_b),
    .REQ_WE(req_we_b), .REQ_FUNC3(req_func3_b), .REQ_ADDR(req_addr_b), .REQ_WDATA(req_wdata_b),
    .RSP_VALID(rsp_valid_b), .RSP_DATA(rsp_data_b), .RSP_ERR(rsp_err_b),
    .M_RD(m_rd_b), .M_WRT(m_wrt_b), .M_FUNC3(m_func3_b), .M_ADDR(m_addr_b), .M_WDATA(m_wdata_b),
    .M_RDATA(m_rdata_b), .dbg_state(dbg_state_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  assign m_rdata   = mem[m_addr[9:2]];
  assign m_rdata_b = mem[m_addr_b[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (m_wrt) begin
      if (m_func3 == 3'b010) mem[m_addr[9:2]] <= m_wdata;
      else begin
        case (m_addr[1:0])
          2'd0: mem[m_addr[9:2]][7:0]   <= m_wdata[7:0];
          2'd1: mem[m_addr[9:2]][15:8]  <= m_wdata[7:0];
          2'd2: mem[m_addr[9:2]][23:16] <= m_wdata[7:0];
          default: mem[m_addr[9:2]][31:24] <= m_wdata[7:0];
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: responses and memory operations of the main instance
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_rsp: observed data %0h err %b expected no response", rsp_data, rsp_err);
      end else begin
        rsp_e = exp_q.pop_front();
        check("rsp_data", 72'(rsp_data), 72'(rsp_e[31:0]));
        check("rsp_err", 72'(rsp_err), 72'(rsp_e[32]));
        check("rsp_cycle", 72'(cyc[15:0]), 72'(rsp_e[48:33]));
      end
    end
    if (m_rd || m_wrt) begin
      check("rd_wrt_exclusive", 72'(m_rd & m_wrt), 72'(0));
      if (exp_m_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_mem_op: observed rd %b wrt %b addr %0h expected none", m_rd, m_wrt, m_addr);
      end else begin
        mop_e = exp_m_q.pop_front();
        check("mem_op", 72'({m_rd, m_wrt, m_func3, m_addr, m_wdata}), 72'(mop_e));
      end
    end
    if (m_rd_b || m_wrt_b) begin
      checks++;
      errors++;
      $error("FAIL b_mem_access: observed rd %b wrt %b addr %0h expected none", m_rd_b, m_wrt_b, m_addr_b);
    end
  end

  // driver tasks
  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic exp_mop(input logic rd, input logic wrt, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    exp_m_q.push_back({rd, wrt, f3, addr, wd});
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int lat, input logic err,
                      input logic [31:0] data, input logic imm);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 72'(req_ready), 72'(1));
    if (imm) check("accept_wait_cycles", 72'(n), 72'(0));
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    exp_q.push_back({16'(cyc + lat), err, data});
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("ready_low_busy", 72'(req_ready), 72'(0));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_m_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_rsp_q", 72'(exp_q.size()), 72'(0));
    check("drain_mop_q", 72'(exp_m_q.size()), 72'(0));
  endtask

  initial begin
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;
    req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_func3_b = 3'd0; req_addr_b = 32'd0; req_wdata_b = 32'd0;
    #12;
    check("rst_req_ready", 72'(req_ready), 72'(1));
    check("rst_outputs", 72'({rsp_valid, rsp_err, rsp_data, m_rd, m_wrt, m_func3}), 72'(0));
    check("rst_m_addr", 72'(m_addr), 72'(0));
    check("rst_m_wdata", 72'(m_wdata), 72'(0));
    check("rst_state", 72'(dbg_state), 72'(0));
    check("rst_b_ready", 72'(req_ready_b), 72'(1));
    @(negedge clk);
    rst_n = 1'b1;

    preload(8'h40, 32'h44332211);
    preload(8'h41, 32'h88776655);

    // loads: aligned, sub-word, sign/zero extension, word-crossing
    exp_mop(1, 0, 3'b010, 32'h100, 0);
    send(0, 3'b010, 32'h100, 0, 2, 0, 32'h44332211, 0);
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b000, 32'h107, 0, 2, 0, 32'hFFFFFF88, 0);
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b100, 32'h107, 0, 2, 0, 32'h00000088, 0);
    exp_mop(1, 0, 3'b010, 32'h100, 0);
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b101, 32'h103, 0, 3, 0, 32'h00005544, 0);
    exp_mop(1, 0, 3'b010, 32'h100, 0);
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b010, 32'h102, 0, 3, 0, 32'h66554433, 0);
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b001, 32'h106, 0, 2, 0, 32'hFFFF8877, 0);
    exp_mop(1, 0, 3'b010, 32'h100, 0);
    send(0, 3'b101, 32'h102, 0, 2, 0, 32'h00004433, 0);

    // misaligned word store splits into four byte stores
    exp_mop(0, 1, 3'b000, 32'h101, 32'hDD);
    exp_mop(0, 1, 3'b000, 32'h102, 32'hCC);
    exp_mop(0, 1, 3'b000, 32'h103, 32'hBB);
    exp_mop(0, 1, 3'b000, 32'h104, 32'hAA);
    send(1, 3'b010, 32'h101, 32'hAABBCCDD, 5, 0, 0, 0);
    drain();
    check("mem_100_after_sw", 72'(mem[8'h40]), 72'(32'hBBCCDD11));
    check("mem_104_after_sw", 72'(mem[8'h41]), 72'(32'h887766AA));
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b010, 32'h104, 0, 2, 0, 32'h887766AA, 0);

    // aligned SW, SH and SB
    exp_mop(0, 1, 3'b010, 32'h108, 32'h12345678);
    send(1, 3'b010, 32'h108, 32'h12345678, 2, 0, 0, 0);
    exp_mop(0, 1, 3'b000, 32'h10A, 32'hEF);
    exp_mop(0, 1, 3'b000, 32'h10B, 32'hBE);
    send(1, 3'b001, 32'h10A, 32'hCAFEBEEF, 3, 0, 0, 0);
    exp_mop(0, 1, 3'b000, 32'h10C, 32'h77);
    send(1, 3'b000, 32'h10C, 32'h00000077, 2, 0, 0, 0);
    exp_mop(1, 0, 3'b010, 32'h108, 0);
    send(0, 3'b010, 32'h108, 0, 2, 0, 32'hBEEF5678, 0);
    exp_mop(1, 0, 3'b010, 32'h10C, 0);
    send(0, 3'b100, 32'h10C, 0, 2, 0, 32'h00000077, 0);

    // illegal funct3 for loads and stores
    send(0, 3'b011, 32'h100, 0, 1, 1, 0, 0);
    send(1, 3'b100, 32'h100, 32'h12345678, 1, 1, 0, 0);
    send(0, 3'b111, 32'h104, 0, 1, 1, 0, 0);

    // byte stores wrap past the top of the address space
    exp_mop(0, 1, 3'b000, 32'hFFFFFFFE, 32'h04);
    exp_mop(0, 1, 3'b000, 32'hFFFFFFFF, 32'h03);
    exp_mop(0, 1, 3'b000, 32'h00000000, 32'h02);
    exp_mop(0, 1, 3'b000, 32'h00000001, 32'h01);
    send(1, 3'b010, 32'hFFFFFFFE, 32'h01020304, 5, 0, 0, 0);
    drain();

    // misalignment disallowed: error response, no memory access
    @(negedge clk);
    check("b_ready", 72'(req_ready_b), 72'(1));
    req_valid_b = 1'b1; req_we_b = 1'b0; req_func3_b = 3'b010; req_addr_b = 32'h102;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    @(negedge clk);
    check("b_lw_rsp", 72'({rsp_valid_b, rsp_err_b, rsp_data_b}), 72'({2'b11, 32'd0}));
    @(negedge clk);
    check("b_rsp_pulse", 72'({rsp_valid_b, req_ready_b}), 72'(2'b01));
    req_valid_b = 1'b1; req_we_b = 1'b1; req_func3_b = 3'b001; req_addr_b = 32'h101;
    req_wdata_b = 32'h1234;
    @(posedge clk);
    #1 req_valid_b = 1'b0;
    @(negedge clk);
    check("b_sh_rsp", 72'({rsp_valid_b, rsp_err_b, rsp_data_b}), 72'({2'b11, 32'd0}));

    // reset in the middle of a split store
    preload(8'h40, 32'h44332211);
    preload(8'h41, 32'h88776655);
    exp_mop(0, 1, 3'b000, 32'h101, 32'hDD);
    exp_mop(0, 1, 3'b000, 32'h102, 32'hCC);
    @(negedge clk);
    check("req_ready_pre_abort", 72'(req_ready), 72'(1));
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 32'h101;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_ready", 72'(req_ready), 72'(1));
    check("abort_outputs", 72'({rsp_valid, rsp_err, rsp_data, m_rd, m_wrt, m_func3}), 72'(0));
    check("abort_m_addr_wdata", 72'({m_addr, m_wdata}), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 72'(req_ready), 72'(1));
    check("abort_mem_100", 72'(mem[8'h40]), 72'(32'h44CCDD11));
    check("abort_mem_104", 72'(mem[8'h41]), 72'(32'h88776655));
    check("abort_mop_q", 72'(exp_m_q.size()), 72'(0));

    // back-to-back: store then load accepted on the cycle after the response
    exp_mop(0, 1, 3'b000, 32'h104, 32'h5A);
    send(1, 3'b000, 32'h104, 32'h0000005A, 2, 0, 0, 0);
    drain();
    exp_mop(1, 0, 3'b010, 32'h104, 0);
    send(0, 3'b100, 32'h104, 0, 2, 0, 32'h0000005A, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
